// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage owning the PC, a req/gnt/rvalid memory port,
// a prefetch FIFO and the IF/ID register.
// Optional: define FETCH_PERF_CNT_EN to build the bubble/redirect performance counters;
// otherwise perf_bubbles/perf_redirects are tied to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        id_branch,
    input  logic [31:0] id_branch_target,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_redirects
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_instr [BUF_DEPTH];
    logic [31:0]   fifo_pc    [BUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          redirect;
    logic [31:0]   target;
    logic          push;
    logic          pop;
    logic          resp_done;
    logic          room_now;
    logic          room_next;
    logic          redirect_to_req;

    assign redirect        = id_branch | id_jump;
    assign target          = id_branch ? id_branch_target : id_jump_target;
    assign resp_done       = (state == WAIT || state == DROP) && imem_rvalid;
    // A response arriving in the redirect cycle is discarded by the flush.
    assign push            = state == WAIT && imem_rvalid && !redirect;
    assign pop             = !redirect && !id_stall && count != '0;
    assign count_next      = redirect ? '0 : count + CW'(push) - CW'(pop);
    assign room_now        = count < CW'(BUF_DEPTH);
    assign room_next       = count_next < CW'(BUF_DEPTH);
    // Redirect may reissue at once unless a granted response is still in flight.
    assign redirect_to_req = state == IDLE || (state == REQ && !imem_gnt) || resp_done;

    // Fetch FSM: owns fetch_pc and the registered memory request outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_ADDR;
        end else if (redirect) begin
            fetch_pc  <= target;
            state     <= redirect_to_req ? REQ : DROP;
            imem_req  <= redirect_to_req;
            imem_addr <= {target[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: if (room_now) begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= {fetch_pc[31:2], 2'b00};
                end
                REQ: if (imem_gnt) begin
                    state    <= WAIT;
                    imem_req <= 1'b0;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                WAIT: if (imem_rvalid) begin
                    state     <= room_next ? REQ : IDLE;
                    imem_req  <= room_next;
                    imem_addr <= {fetch_pc[31:2], 2'b00};
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage: the outstanding request's PC is fetch_pc-4 since fetch_pc advanced on gnt.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc - 32'd4;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (!rst || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count_next;
        end
    end

    // IF/ID register: redirect bubble, stall hold, pop, or bubble with PC held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_instr <= '0;
            if_pc    <= RESET_PC;
            if_pc4   <= RESET_PC + 32'd4;
            if_valid <= 1'b0;
        end else if (redirect) begin
            if_instr <= '0;
            if_valid <= 1'b0;
        end else if (!id_stall) begin
            if_instr <= pop ? fifo_instr[rd_ptr] : '0;
            if_valid <= pop;
            if (pop) begin
                if_pc  <= fifo_pc[rd_ptr];
                if_pc4 <= fifo_pc[rd_ptr] + 32'd4;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic bubble;

    assign bubble = redirect || (!id_stall && count == '0);

    // Performance counters: bubbles loaded into IF/ID and redirect cycles, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_bubbles   <= '0;
            perf_redirects <= '0;
        end else begin
            perf_bubbles   <= perf_bubbles + 32'(bubble);
            perf_redirects <= perf_redirects + 32'(redirect);
        end
    end
`else
    assign perf_bubbles   = '0;
    assign perf_redirects = '0;
`endif
endmodule
